// File: rtl/bitserial_logic_pkg.sv
// bitserial_logic_pkg: shared state encoding and 2-input function select codes
// for the bit-serial logic sequencer.
package bitserial_logic_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic [3:0] OP_ZERO   = 4'b0000;
    localparam logic [3:0] OP_AND    = 4'b0001;
    localparam logic [3:0] OP_PASS_X = 4'b0011;
    localparam logic [3:0] OP_PASS_Y = 4'b0101;
    localparam logic [3:0] OP_XOR    = 4'b0110;
    localparam logic [3:0] OP_OR     = 4'b0111;
    localparam logic [3:0] OP_NOR    = 4'b1000;
    localparam logic [3:0] OP_XNOR   = 4'b1001;
    localparam logic [3:0] OP_NOT_Y  = 4'b1010;
    localparam logic [3:0] OP_NOT_X  = 4'b1100;
    localparam logic [3:0] OP_NAND   = 4'b1110;
    localparam logic [3:0] OP_ONE    = 4'b1111;

    // op is a truth table read MSB-first: z = op[3 - {x,y}], and 3 - n == ~n for 2 bits
    function automatic logic cell_eval(input logic [3:0] op, input logic x, input logic y);
        return op[~{x, y}];
    endfunction

endpackage

// File: rtl/bitserial_logic_seq_cell.sv
// logic_cell: combinational 1-bit cell computing any of the 16 two-input
// Boolean functions selected by op.
module logic_cell
    import bitserial_logic_pkg::*;
(
    input  logic [3:0] op,
    input  logic       x,
    input  logic       y,
    output logic       z
);

    assign z = cell_eval(op, x, y);

endmodule

// File: rtl/bitserial_logic_seq.sv
// bitserial_logic_seq: streams two WIDTH-bit operands LSB-first through one
// shared logic_cell, producing a WIDTH-bit result after WIDTH+1 cycles.
module bitserial_logic_seq
    import bitserial_logic_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    state_e           state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] sa_q, sb_q, acc_q, acc_d, result_q;
    logic [CNT_W-1:0] cnt_q;
    logic             zero_q, cell_z, last;

    logic_cell u_cell (
        .op (op_q),
        .x  (sa_q[0]),
        .y  (sb_q[0]),
        .z  (cell_z)
    );

    assign acc_d = {cell_z, acc_q[WIDTH-1:1]};
    assign last  = cnt_q == CNT_W'(WIDTH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            sa_q     <= '0;
            sb_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    op_q    <= op;
                    sa_q    <= a;
                    sb_q    <= b;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= RUN;
                end
                RUN: if (abort) begin
                    state_q <= IDLE;
                end else begin
                    acc_q <= acc_d;
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    // hold on the final bit so the counter never wraps
                    cnt_q <= last ? cnt_q : cnt_q + 1'b1;
                    if (last) begin
                        state_q  <= DONE;
                        result_q <= acc_d;
                        zero_q   <= acc_d == '0;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = state_q != IDLE;
    assign done   = state_q == DONE;
    assign result = result_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_bitserial_logic_seq.sv
// tb_bitserial_logic_seq: directed vectors with hand-computed results for the
// bit-serial logic sequencer; outputs are sampled on the falling edge.
module tb_bitserial_logic_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] op = '0;
    logic [7:0] a = '0, b = '0;
    logic       busy, done, zero;
    logic [7:0] result;
    int         n_vec = 0;
    int         n_bad = 0;

    bitserial_logic_seq #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .abort  (abort),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // called at a falling edge; start is sampled at the next rising edge (E0)
    task automatic launch(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        check("busy_rise", busy, 1);
    endtask

    // done must appear after edge E8, last one cycle, then drop back to idle
    task automatic finish(input string tag, input logic [7:0] exp_res, input logic exp_zero);
        int cyc = 0;
        while (!done && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_lat"}, cyc, 8);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_res"}, result, exp_res);
        check({tag, "_zero"}, zero, exp_zero);
        @(negedge clk);
        check({tag, "_pulse"}, done, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res", result, 0);
        check("rst_zero", zero, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        launch(4'b0001, 8'hF0, 8'h3C);
        finish("and", 8'h30, 0);

        launch(4'b0110, 8'hAA, 8'hFF);
        finish("xor", 8'h55, 0);
        launch(4'b1001, 8'h0F, 8'h0F);
        finish("xnor", 8'hFF, 0);

        launch(4'b0000, 8'hFF, 8'hFF);
        finish("zero", 8'h00, 1);
        launch(4'b1111, 8'hFF, 8'hFF);
        finish("one", 8'hFF, 0);

        // restart attempts during RUN and DONE must be ignored, not queued
        begin
            int pulses = 0;
            int at = -1;
            launch(4'b0111, 8'h81, 8'h18);
            for (int i = 1; i <= 8; i++) begin
                start = (i == 3 || i == 8);
                op = 4'b0000;
                a = 8'h00;
                b = 8'h00;
                @(negedge clk);
                check("or_busy_hold", busy, 1);
                if (done) begin
                    pulses++;
                    at = i;
                end
            end
            start = 1'b0;
            check("or_pulses", pulses, 1);
            check("or_lat", at, 8);
            check("or_res", result, 8'h99);
            @(negedge clk);
            check("or_pulse", done, 0);
            check("or_idle", busy, 0);
            @(negedge clk);
            check("or_noqueue", busy, 0);
        end

        launch(4'b0001, 8'hF0, 8'h3C);
        finish("and2", 8'h30, 0);
        launch(4'b1110, 8'hF0, 8'h3C);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_res", result, 8'h30);
        check("abort_zero", zero, 0);
        repeat (8) begin
            @(negedge clk);
            check("abort_nodone", done, 0);
        end

        launch(4'b0110, 8'hAA, 8'hFF);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_res", result, 0);
        check("arst_zero", zero, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        launch(4'b0110, 8'hAA, 8'hFF);
        finish("post_rst", 8'h55, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
